fb_line_fetch: RTL
==================

Name: fb_line_fetch

Overview:
Wishbone master that copies one display line of 16bpp pixel words from SDRAM into the framebuffer line buffer.
- Sits between the SDRAM Wishbone slave (upstream data source) and the line-buffer write port (downstream consumer) that feeds the LCD controller.
- Triggered once per line by a start pulse carrying the line index; reports completion, errors and overruns.

Parameters:
- WB_AW, 21, Wishbone word-address width.
- LINE_WORDS, 240, 32-bit words per line (480 px at 2 px/word).
- LINES, 272, number of valid lines; line_idx must be below this.
- LB_AW, 8, line-buffer word-address width.
- TIMEOUT, 255, maximum cycles to wait for an ack before aborting.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cfg_base  in  WB_AW  word address of line 0 in SDRAM
- start  in  1  single-cycle request to fetch a line
- line_idx  in  9  line to fetch, sampled on start
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable, tied 0
- wb_adr  out  WB_AW  Wishbone word address
- wb_dat_i  in  32  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge
- lb_we  out  1  line-buffer write strobe
- lb_waddr  out  LB_AW  line-buffer word index
- lb_wdata  out  32  line-buffer data
- busy  out  1  a fetch is in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky: timeout or bad line_idx
- overrun  out  1  sticky: start received while busy
- clr_flags  in  1  synchronous clear of err and overrun

Behaviour:
- Reset (async, resetn=0): all outputs are 0, state is IDLE, word counter idx=0, sticky flags cleared. Assertion mid-fetch aborts the fetch immediately: wb_cyc/wb_stb drop in the same instant and no further lb_we is issued.
- State machine: IDLE, REQ, GAP, FIN.
- IDLE, start=1:
  - If line_idx >= LINES: set err, stay IDLE, no bus activity.
  - Otherwise latch line_base = (cfg_base + line_idx*LINE_WORDS) mod 2^WB_AW, set idx=0, busy=1, go to REQ.
  - The product is 17-bit unsigned, zero-extended before the add; wrap-around at 2^WB_AW is silent.
- REQ:
  - wb_cyc=wb_stb=1, wb_adr = line_base + idx (mod 2^WB_AW), wb_we=0.
  - The wait counter increments each cycle without ack.
  - On wb_ack: lb_we=1, lb_waddr=idx, lb_wdata=wb_dat_i, all registered and visible the cycle after the ack. Then idx increments and the wait counter clears.
  - If idx was LINE_WORDS-1, go to FIN; else go to GAP.
- GAP: wb_stb=0, wb_cyc=0 for exactly one cycle so the clock-crossing slave sees a fresh transaction, then go to REQ.
- Timeout: if the wait counter reaches TIMEOUT in REQ without ack, set err, drop cyc/stb, busy=0, no done, go to IDLE. Words already written remain in the line buffer.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Ack outside REQ is ignored; it produces no lb_we.
- start while busy (REQ/GAP/FIN): set overrun; the request is dropped and the current fetch continues unaffected.
- clr_flags clears err/overrun. If it coincides with a setting event in the same cycle, the set wins.
- Steady-state throughput is one word per (ack latency + 2) cycles. Minimum line time with zero-wait ack is 2*LINE_WORDS + 1 cycles from start to done.

Test Plan:
- Basic fetch: cfg_base=0x01000, line_idx=3, slave acks 1 cycle after stb with data=addr -> wb_adr runs 0x012D0..0x013BF; 240 lb_we pulses with lb_waddr 0..239 and lb_wdata=0x012D0+i; exactly one done pulse; busy low afterwards.
- Address wrap: cfg_base=0x1FFF00, line_idx=1 -> first wb_adr = 0x1FFFF0; after 16 words wb_adr wraps to 0x000000; err stays 0.
- Bad index: start with line_idx=272 -> err=1 the next cycle, wb_cyc never asserts, no done; clr_flags then clears err.
- Timeout: slave stops acking after word 10 -> err=1 exactly TIMEOUT=255 cycles after the last ack; cyc/stb drop; busy=0; no done; 11 lb_we pulses total.
- Overrun: second start 50 cycles into a fetch -> overrun=1; the fetch still completes all 240 words and one done; no second fetch starts.
- Reset mid-fetch: resetn low during word 100 -> wb_cyc, wb_stb, lb_we and busy go to 0 without waiting for a clock edge; after release the block is IDLE and a new start performs a full 240-word fetch.

Source files
------------

// File: rtl/fb_line_fetch.sv
// Wishbone read master that copies one display line of 16bpp pixel words
// from SDRAM into the LCD line buffer, one single-beat transaction per word.
module fb_line_fetch #(
  parameter int WB_AW      = 21,
  parameter int LINE_WORDS = 240,
  parameter int LINES      = 272,
  parameter int LB_AW      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WB_AW-1:0] cfg_base,
  input  logic             start,
  input  logic [8:0]       line_idx,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [WB_AW-1:0] wb_adr,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack,
  output logic             lb_we,
  output logic [LB_AW-1:0] lb_waddr,
  output logic [31:0]      lb_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             overrun,
  input  logic             clr_flags
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0]       NUM_LINES = 9'(LINES);
  localparam logic [LB_AW-1:0] LAST_IDX  = LB_AW'(LINE_WORDS - 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, FIN} state_t;

  state_t           state;
  logic [LB_AW-1:0] idx;
  logic [TW-1:0]    wait_cnt;
  logic [16:0]      line_off;
  logic [WB_AW-1:0] line_base;

  assign line_off  = 17'(line_idx) * 17'(LINE_WORDS);
  assign line_base = cfg_base + WB_AW'(line_off);
  assign wb_we     = 1'b0;

  // The wait counter clears on every ack and also runs through GAP, so the
  // abort lands exactly TIMEOUT cycles after the last accepted word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_adr   <= '0;
      lb_we    <= 1'b0;
      lb_waddr <= '0;
      lb_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      lb_we <= 1'b0;
      done  <= 1'b0;
      // Clearing comes first so a set event later in this block wins.
      if (clr_flags) begin
        err     <= 1'b0;
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (line_idx >= NUM_LINES) begin
              err <= 1'b1;
            end else begin
              wb_adr   <= line_base;
              idx      <= '0;
              wait_cnt <= '0;
              busy     <= 1'b1;
              wb_cyc   <= 1'b1;
              wb_stb   <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (start) overrun <= 1'b1;
          if (wb_ack) begin
            lb_we    <= 1'b1;
            lb_waddr <= idx;
            lb_wdata <= wb_dat_i;
            idx      <= idx + 1'b1;
            wait_cnt <= '0;
            wb_adr   <= wb_adr + 1'b1;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            state    <= (idx == LAST_IDX) ? FIN : GAP;
          end else if (wait_cnt == WAIT_LAST) begin
            err    <= 1'b1;
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (start) overrun <= 1'b1;
          wait_cnt <= wait_cnt + 1'b1;
          wb_cyc   <= 1'b1;
          wb_stb   <= 1'b1;
          state    <= REQ;
        end
        FIN: begin
          if (start) overrun <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
